stack_alu_sequencer: RTL and testbench
======================================

# stack_alu_sequencer

Upstream instruction sequencer for the stack-based ALU. It holds a small program of (opcode, operand) pairs loaded over a write port. On `start` it issues the program to the ALU one instruction per cycle, then captures the ALU top-of-stack and a sticky overflow flag as the program result. The ALU keeps its existing interface; this block drives its `in`/`opcode` pins and observes its `out`/`overflow` pins.

## Interface
- `N`, 4 — operand/result width; must match ALU `n`.
- `DEPTH`, 16 — program memory entries; power of two.
- `AW`, $clog2(DEPTH) — address width (derived).

Ports:
- `clk`  in  1  — clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `load_valid`  in  1  — write one instruction this cycle.
- `load_opcode`  in  3  — ALU opcode: 100 add, 101 mul, 110 push, 111 pop, 0xx no-op.
- `load_data`  in  N  — operand, used by push.
- `load_ready`  out  1  — write accepted when `load_valid & load_ready`.
- `prog_clr`  in  1  — empty the program (IDLE only).
- `prog_len`  out  AW+1  — number of stored instructions.
- `start`  in  1  — run the program (IDLE only).
- `busy`  out  1  — high in RUN/DRAIN.
- `done`  out  1  — one-cycle pulse when the result is valid.
- `alu_in`  out  N  — to ALU `in`.
- `alu_opcode`  out  3  — to ALU `opcode`.
- `alu_out`  in  N  — from ALU `out`.
- `alu_overflow`  in  1  — from ALU `overflow`.
- `result`  out  N  — captured ALU output; held until the next done.
- `result_overflow`  out  1  — sticky OR of ALU overflow over the last run.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `load_ready = (prog_len < DEPTH)`.
  - An accepted load writes `mem[prog_len]` and increments `prog_len`.
  - `prog_clr` sets `prog_len` to 0. If `prog_clr` and `load_valid` arrive together, clear wins and the load is dropped.
  - `start` with `prog_len > 0` goes to RUN: clears `result_overflow`, sets `pc = 0`.
  - `start` with `prog_len == 0` is ignored. No done pulse.
- RUN:
  - Registered outputs present `mem[pc]` for exactly one cycle each, and `pc` increments.
  - After entry `prog_len-1` has been presented, the FSM goes to DRAIN.
  - `load_valid`, `prog_clr` and `start` are ignored (`load_ready = 0`).
- DRAIN: one cycle. Capture `result <= alu_out` and OR `alu_overflow` into `result_overflow`, then go to DONE.
- DONE: `done = 1` for one cycle, then IDLE. The program is retained, so it can be re-run with `start`.
- Overflow sampling:
  - On the edge after each add or mul instruction is presented, `result_overflow |= alu_overflow`.
  - Push, pop and no-op never set it.
- Outside RUN, `alu_opcode = 000` (no-op) and `alu_in = 0`, so the ALU stack is never disturbed while idle.
- Stack underflow and overflow inside the ALU are the ALU's behaviour. The sequencer does not check them.

## Timing
- Reset values: `load_ready = 1`, `prog_len = 0`, `busy = 0`, `done = 0`, `alu_in = 0`, `alu_opcode = 000`, `result = 0`, `result_overflow = 0`, state IDLE, `pc = 0`. Memory contents are don't-care.
- Edge E0 accepts `start`. Instruction k is on `alu_*` during cycle k+1 and is sampled by the ALU at edge E(k+1).
- With L = `prog_len`:
  - `result` is captured at edge E(L+1).
  - `done` is high during cycle L+2.
  - `busy` is high during cycles 1..L+1.
  - Total latency from start to done is L+2 cycles.
- Reset mid-run: asynchronously returns every output to its reset value and empties the program. The ALU's own reset is the top level's responsibility.

## Configuration
- `SEQ_OVF_ABORT_EN` defined:
  - The first sampled add/mul overflow during RUN aborts the run: the FSM goes to DRAIN at the next edge and no further instructions are issued.
  - `result` = `alu_out` at that point, `result_overflow = 1`, `done` pulses normally.
- Undefined: overflow is only recorded and the whole program always runs.

## Test plan
- Load push 5, push 3, add; start → `alu_*` shows 110/5, 110/3, 100/x in cycles 1–3; done in cycle 5; `result = 8`, `result_overflow = 0`.
- Load push 5, push 5, mul; start → `result = 9` (25 mod 16), `result_overflow = 1`. With `SEQ_OVF_ABORT_EN`, same values and the same done cycle.
- With `SEQ_OVF_ABORT_EN`: load push 7, push 7, mul, push 1, add; start → overflow sampled after mul; push 1 and add are never presented; done 1 cycle after the abort edge; `result_overflow = 1`.
- Load 17 instructions with DEPTH=16 → `load_ready` drops after the 16th; 17th ignored; `prog_len = 16`. Then `prog_clr` → `prog_len = 0`; `start` → no busy, no done.
- Assert `rst` during cycle 2 of a 3-instruction run → all outputs at reset values immediately; `alu_opcode = 000`; `prog_len = 0`.
- Run push 2, push 4, add twice in succession without reloading → both runs give `result = 6`, with identical cycle timing.

Source files
------------

// File: rtl/stack_alu_sequencer.sv
// Program sequencer for the stack ALU: loads (opcode, operand) pairs, replays them, captures the result.
// Optional SEQ_OVF_ABORT_EN: first add/mul overflow during a run stops issuing and drains early.
module stack_alu_sequencer #(
    parameter int N     = 4,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    input  logic [2:0]    load_opcode,
    input  logic [N-1:0]  load_data,
    output logic          load_ready,
    input  logic          prog_clr,
    output logic [AW:0]   prog_len,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  alu_in,
    output logic [2:0]    alu_opcode,
    input  logic [N-1:0]  alu_out,
    input  logic          alu_overflow,
    output logic [N-1:0]  result,
    output logic          result_overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0]  OP_NOP = 3'b000;
    localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);

    logic [2:0]   mem_op   [DEPTH];
    logic [N-1:0] mem_data [DEPTH];

    logic [1:0]  state;
    logic [AW:0] pc;
    logic        start_go;
    logic        load_we;
    logic        arith;
    logic        ovf_hit;
    logic        abort;
    logic        last;

    assign load_ready = (state == S_IDLE) && (prog_len < FULL);
    assign busy       = (state == S_RUN) || (state == S_DRAIN);
    assign done       = (state == S_DONE);

    assign start_go = (state == S_IDLE) && start && !prog_clr
                   && (prog_len != '0);
    assign load_we  = load_valid && load_ready && !prog_clr && !start_go;

    // Add and mul are the only opcodes whose overflow is meaningful.
    assign arith   = (alu_opcode[2:1] == 2'b10);
    assign ovf_hit = (state == S_RUN) && arith && alu_overflow;
    assign last    = (pc == prog_len);

`ifdef SEQ_OVF_ABORT_EN
    assign abort = ovf_hit;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (load_we) begin
            mem_op[prog_len[AW-1:0]]   <= load_opcode;
            mem_data[prog_len[AW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            pc              <= '0;
            prog_len        <= '0;
            alu_in          <= '0;
            alu_opcode      <= OP_NOP;
            result          <= '0;
            result_overflow <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (prog_clr) begin
                        prog_len <= '0;
                    end else if (load_we) begin
                        prog_len <= prog_len + 1'b1;
                    end
                    // pc is always 0 here, so it addresses the first entry.
                    if (start_go) begin
                        state           <= S_RUN;
                        pc              <= pc + 1'b1;
                        alu_opcode      <= mem_op[pc[AW-1:0]];
                        alu_in          <= mem_data[pc[AW-1:0]];
                        result_overflow <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (ovf_hit) begin
                        result_overflow <= 1'b1;
                    end
                    if (abort || last) begin
                        state      <= S_DRAIN;
                        alu_opcode <= OP_NOP;
                        alu_in     <= '0;
                    end else begin
                        alu_opcode <= mem_op[pc[AW-1:0]];
                        alu_in     <= mem_data[pc[AW-1:0]];
                        pc         <= pc + 1'b1;
                    end
                end
                S_DRAIN: begin
                    result          <= alu_out;
                    result_overflow <= result_overflow | alu_overflow;
                    pc              <= '0;
                    state           <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Scoreboard bench for stack_alu_sequencer with a behavioural stack ALU model.
// Expected issue/result values are hand-computed; monitors pop and compare on DUT activity.
module tb_stack_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic [2:0] load_opcode = 3'b000;
    logic [3:0] load_data = 4'd0;
    logic       load_ready;
    logic       prog_clr = 1'b0;
    logic [4:0] prog_len;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] alu_in;
    logic [2:0] alu_opcode;
    logic [3:0] alu_out;
    logic       alu_overflow;
    logic [3:0] result;
    logic       result_overflow;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] res;
        logic       ovf;
        int         lat;
        int         sc;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] iss_q[$];

    stack_alu_sequencer #(.N(4), .DEPTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .load_valid(load_valid),
        .load_opcode(load_opcode),
        .load_data(load_data),
        .load_ready(load_ready),
        .prog_clr(prog_clr),
        .prog_len(prog_len),
        .start(start),
        .busy(busy),
        .done(done),
        .alu_in(alu_in),
        .alu_opcode(alu_opcode),
        .alu_out(alu_out),
        .alu_overflow(alu_overflow),
        .result(result),
        .result_overflow(result_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: registered stack, out = top, overflow flags the op being presented.
    logic [3:0] stk [16];
    logic [4:0] sp;
    logic [3:0] ta, tb2;
    logic [7:0] sum, prod;

    assign ta   = (sp > 0) ? stk[sp[3:0] - 4'd1] : 4'd0;
    assign tb2  = (sp > 1) ? stk[sp[3:0] - 4'd2] : 4'd0;
    assign sum  = {4'd0, ta} + {4'd0, tb2};
    assign prod = {4'd0, ta} * {4'd0, tb2};
    assign alu_out = ta;
    assign alu_overflow = (sp > 1) &&
        (((alu_opcode == 3'b100) && (sum > 8'd15)) ||
         ((alu_opcode == 3'b101) && (prod > 8'd15)));

    always @(posedge clk) begin
        if (rst) begin
            sp <= 5'd0;
        end else begin
            case (alu_opcode)
                3'b110: if (sp < 16) begin
                    stk[sp[3:0]] <= alu_in;
                    sp <= sp + 5'd1;
                end
                3'b111: if (sp > 0) sp <= sp - 5'd1;
                3'b100: if (sp > 1) begin
                    stk[sp[3:0] - 4'd2] <= sum[3:0];
                    sp <= sp - 5'd1;
                end
                3'b101: if (sp > 1) begin
                    stk[sp[3:0] - 4'd2] <= prod[3:0];
                    sp <= sp - 5'd1;
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Issue monitor: every non-noop presented to the ALU must match the queue head.
    always @(negedge clk) begin
        if (!rst && alu_opcode != 3'b000) begin
            if (iss_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL issue_unexpected actual=%0d/%0d required=none",
                         alu_opcode, alu_in);
            end else begin
                logic [6:0] e;
                e = iss_q.pop_front();
                chk("issue", {alu_opcode, alu_in}, {25'd0, e});
            end
        end
    end

    // Result monitor: each done pulse pops one expected result.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL done_unexpected actual=1 required=0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", {28'd0, result}, {28'd0, e.res});
                chk("result_ovf", {31'd0, result_overflow}, {31'd0, e.ovf});
                chk("done_cycle", cyc - e.sc + 1, e.lat);
            end
        end
    end

    task automatic load(input logic [2:0] op, input logic [3:0] d,
                        input logic expect_issue);
        load_valid  = 1'b1;
        load_opcode = op;
        load_data   = d;
        if (expect_issue) iss_q.push_back({op, d});
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic clear();
        prog_clr = 1'b1;
        @(negedge clk);
        prog_clr = 1'b0;
    endtask

    task automatic run_prog(input logic [3:0] er, input logic eo,
                            input int lat);
        int n;
        exp_t e;
        e.res = er;
        e.ovf = eo;
        e.lat = lat;
        e.sc  = cyc + 1;
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("run_load_ready", {31'd0, load_ready}, 32'd0);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL done_timeout actual=0 required=1");
        end
        @(negedge clk);
        chk("idle_opcode", {29'd0, alu_opcode}, 32'd0);
        chk("result_hold", {28'd0, result}, {28'd0, er});
    endtask

    initial begin
        int cnt;
        #2;
        chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_prog_len", {27'd0, prog_len}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_alu_in", {28'd0, alu_in}, 32'd0);
        chk("rst_alu_opcode", {29'd0, alu_opcode}, 32'd0);
        chk("rst_result", {28'd0, result}, 32'd0);
        chk("rst_result_ovf", {31'd0, result_overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // push 5, push 3, add -> 8
        load(3'b110, 4'd5, 1'b1);
        load(3'b110, 4'd3, 1'b1);
        load(3'b100, 4'd0, 1'b1);
        chk("len3", {27'd0, prog_len}, 32'd3);
        run_prog(4'd8, 1'b0, 5);

        // push 5, push 5, mul -> 25 mod 16 = 9 with overflow
        clear();
        load(3'b110, 4'd5, 1'b1);
        load(3'b110, 4'd5, 1'b1);
        load(3'b101, 4'd0, 1'b1);
        run_prog(4'd9, 1'b1, 5);

        // push 7, push 7, mul, push 1, add
        clear();
        load(3'b110, 4'd7, 1'b1);
        load(3'b110, 4'd7, 1'b1);
        load(3'b101, 4'd0, 1'b1);
`ifdef SEQ_OVF_ABORT_EN
        load(3'b110, 4'd1, 1'b0);
        load(3'b100, 4'd0, 1'b0);
        run_prog(4'd1, 1'b1, 5);
`else
        load(3'b110, 4'd1, 1'b1);
        load(3'b100, 4'd0, 1'b1);
        run_prog(4'd2, 1'b1, 7);
`endif

        // Fill past capacity
        clear();
        for (int i = 0; i < 17; i++) begin
            chk("fill_ready", {31'd0, load_ready}, (i < 16) ? 32'd1 : 32'd0);
            load(3'b110, i[3:0], 1'b0);
        end
        chk("full_len", {27'd0, prog_len}, 32'd16);
        chk("full_ready", {31'd0, load_ready}, 32'd0);
        clear();
        chk("clr_len", {27'd0, prog_len}, 32'd0);
        load(3'b110, 4'd1, 1'b0);
        chk("len1", {27'd0, prog_len}, 32'd1);
        prog_clr   = 1'b1;
        load_valid = 1'b1;
        @(negedge clk);
        prog_clr   = 1'b0;
        load_valid = 1'b0;
        chk("clr_wins", {27'd0, prog_len}, 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy || done) cnt++;
            @(negedge clk);
        end
        chk("empty_start", cnt, 32'd0);

        // Reset during cycle 2 of a 3-instruction run
        load(3'b110, 4'd1, 1'b0);
        load(3'b110, 4'd2, 1'b0);
        load(3'b100, 4'd0, 1'b0);
        iss_q.push_back({3'b110, 4'd1});
        iss_q.push_back({3'b110, 4'd2});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_alu_opcode", {29'd0, alu_opcode}, 32'd0);
        chk("mid_alu_in", {28'd0, alu_in}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_prog_len", {27'd0, prog_len}, 32'd0);
        chk("mid_load_ready", {31'd0, load_ready}, 32'd1);
        chk("mid_result", {28'd0, result}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Re-run the same program twice
        load(3'b110, 4'd2, 1'b1);
        load(3'b110, 4'd4, 1'b1);
        load(3'b100, 4'd0, 1'b1);
        run_prog(4'd6, 1'b0, 5);
        iss_q.push_back({3'b110, 4'd2});
        iss_q.push_back({3'b110, 4'd4});
        iss_q.push_back({3'b100, 4'd0});
        run_prog(4'd6, 1'b0, 5);

        repeat (3) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 32'd0);
        chk("iss_q_empty", iss_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
